pong_game_engine: RTL



---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_game_engine_paddle.sv | 29 ++
 rtl/pong_game_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared state encoding, direction encoding and playfield geometry for the pong game engine.
package pong_pkg;

    typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} state_t;
    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} xdir_t;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} ydir_t;

    localparam logic [5:0] PAD_MIN   = 6'd5;
    localparam logic [5:0] PAD_MAX   = 6'd58;
    localparam logic [5:0] PAD_H     = 6'd6;
    localparam logic [5:0] BALL_YMIN = 6'd5;
    localparam logic [5:0] BALL_YMAX = 6'd63;
    localparam logic [5:0] P1_HIT_X  = 6'd2;
    localparam logic [5:0] P2_HIT_X  = 6'd61;
    localparam logic [5:0] CTR_X     = 6'd31;
    localparam logic [5:0] CTR_Y     = 6'd34;
    localparam logic [5:0] PAD_RESET = 6'd31;

    // True when row y lies within the paddle whose top row is top.
    function automatic logic on_paddle(input logic [5:0] y, input logic [5:0] top);
        logic [6:0] bottom;
        bottom = {1'b0, top} + {1'b0, PAD_H} - 7'd1;
        return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} <= bottom);
    endfunction

endpackage

// File: rtl/pong_game_engine_paddle.sv
// Paddle position register: one-row move per tick, clamped to the legal paddle range.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic       restart,
    input  logic       up,
    input  logic       dn,
    output logic [5:0] top
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= PAD_RESET;
        end else if (tick) begin
            if (restart) begin
                top <= PAD_RESET;
            end else if (enable && up && !dn) begin
                top <= (top <= PAD_MIN) ? PAD_MIN : top - 6'd1;
            end else if (enable && dn && !up) begin
                top <= (top >= PAD_MAX) ? PAD_MAX : top + 6'd1;
            end
        end
    end

endmodule

// File: rtl/pong_game_engine.sv
// Pong game-state engine: ball, paddles, scores and serve/point/game-over flow, one step per frame tick.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int BALL_DIV   = 2,
    parameter int POINT_HOLD = 32,
    parameter int WIN_SCORE  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       serve,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic       game_over,
    output logic       winner
);

    localparam int              HOLD_W    = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
    localparam logic [3:0]      DIV_LAST  = 4'(BALL_DIV - 1);
    localparam logic [2:0]      WIN_LAST  = 3'(WIN_SCORE - 1);

    state_t              state;
    xdir_t               dx;
    xdir_t               serve_dir;
    ydir_t               dy;
    logic [3:0]          div;
    logic [HOLD_W-1:0]   hold;

    xdir_t               ndx;
    ydir_t               ndy;
    logic [5:0]          nbx;
    logic [5:0]          nby;
    logic                miss_left;
    logic                miss_right;
    logic                pad_en;
    logic                pad_restart;

    assign pad_en      = (state != GAME_OVER);
    assign pad_restart = (state == GAME_OVER) && serve;

    pong_paddle_ctrl u_pad1 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .enable  (pad_en),
        .restart (pad_restart),
        .up      (p1_up),
        .dn      (p1_dn),
        .top     (p1y)
    );

    pong_paddle_ctrl u_pad2 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .enable  (pad_en),
        .restart (pad_restart),
        .up      (p2_up),
        .dn      (p2_dn),
        .top     (p2y)
    );

    // Candidate ball step; paddle tops are still the pre-move values here since they update on the same edge.
    always_comb begin
        nbx        = bx;
        ndx        = dx;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if (dx == DIR_LEFT) begin
            if (bx == P1_HIT_X) begin
                if (on_paddle(by, p1y)) begin
                    ndx = DIR_RIGHT;
                    nbx = P1_HIT_X + 6'd1;
                end else begin
                    miss_left = 1'b1;
                end
            end else begin
                nbx = bx - 6'd1;
            end
        end else begin
            if (bx == P2_HIT_X) begin
                if (on_paddle(by, p2y)) begin
                    ndx = DIR_LEFT;
                    nbx = P2_HIT_X - 6'd1;
                end else begin
                    miss_right = 1'b1;
                end
            end else begin
                nbx = bx + 6'd1;
            end
        end

        nby = by;
        ndy = dy;
        if (dy == DIR_UP) begin
            if (by == BALL_YMIN) begin
                ndy = DIR_DOWN;
                nby = BALL_YMIN + 6'd1;
            end else begin
                nby = by - 6'd1;
            end
        end else begin
            if (by == BALL_YMAX) begin
                ndy = DIR_UP;
                nby = BALL_YMAX - 6'd1;
            end else begin
                nby = by + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SERVE;
            bx        <= CTR_X;
            by        <= CTR_Y;
            dx        <= DIR_RIGHT;
            dy        <= DIR_DOWN;
            serve_dir <= DIR_RIGHT;
            div       <= '0;
            hold      <= '0;
            sc1       <= '0;
            sc2       <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else if (tick) begin
            unique case (state)
                SERVE: begin
                    if (serve) begin
                        dx    <= serve_dir;
                        div   <= '0;
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (div != DIV_LAST) begin
                        div <= div + 4'd1;
                    end else begin
                        div <= '0;
                        if (miss_left || miss_right) begin
                            // Ball stays where it was; the loser serves toward the player who just scored.
                            dy <= (dy == DIR_UP) ? DIR_DOWN : DIR_UP;
                            if (miss_right) begin
                                sc1       <= sc1 + 3'd1;
                                serve_dir <= DIR_LEFT;
                                if (sc1 == WIN_LAST) begin
                                    state     <= GAME_OVER;
                                    game_over <= 1'b1;
                                    winner    <= 1'b0;
                                end else begin
                                    hold  <= '0;
                                    state <= POINT;
                                end
                            end else begin
                                sc2       <= sc2 + 3'd1;
                                serve_dir <= DIR_RIGHT;
                                if (sc2 == WIN_LAST) begin
                                    state     <= GAME_OVER;
                                    game_over <= 1'b1;
                                    winner    <= 1'b1;
                                end else begin
                                    hold  <= '0;
                                    state <= POINT;
                                end
                            end
                        end else begin
                            bx <= nbx;
                            by <= nby;
                            dx <= ndx;
                            dy <= ndy;
                        end
                    end
                end
                POINT: begin
                    if (hold == HOLD_LAST) begin
                        bx    <= CTR_X;
                        by    <= CTR_Y;
                        state <= SERVE;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (serve) begin
                        sc1       <= '0;
                        sc2       <= '0;
                        bx        <= CTR_X;
                        by        <= CTR_Y;
                        game_over <= 1'b0;
                        serve_dir <= DIR_RIGHT;
                        state     <= SERVE;
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule
